// File: rtl/itof_pipe_if.sv
// itof_pipe_if: request/result handshake bundle for the int-to-float pipeline.
//   Request side : in_valid, in_ready, in_data[31:0] (signed int), in_tag[TAG_W-1:0]
//   Result side  : out_valid, out_ready, out_data[31:0] (IEEE-754 single), out_tag[TAG_W-1:0]
// The master modport is the requester/consumer (FPU issue and writeback).
// The slave modport is the converter.
interface itof_pipe_if #(
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage valid/ready pipeline that converts a signed 32-bit integer
// to IEEE-754 single precision, rounding to nearest even.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset, clears every pipeline register
//   bus  : itof_pipe_if slave (request in_*, result out_*, tag passed through)
// Stage 1 takes sign and magnitude. Stage 2 normalises so that the leading one
// sits at bit 31. Stage 3 rounds, packs the result, and is the output register.
module itof_pipe #(
  parameter int unsigned TAG_W = 5
) (
  input logic      clk,
  input logic      rstn,
  itof_pipe_if.slave bus
);

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_zero_q, s1_zero_d;
  logic [31:0]      s1_abs_q, s1_abs_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_zero_q, s2_zero_d;
  logic [4:0]       s2_pos_q, s2_pos_d;
  logic [31:0]      s2_norm_q, s2_norm_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  // Stage 3 (output) registers
  logic             s3_valid_q, s3_valid_d;
  logic [31:0]      s3_data_q, s3_data_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;

  // A stage may load when it is empty or its content moves on this cycle.
  // This forms a combinational ready chain from out_ready back to in_ready,
  // so empty stages never wait on a stalled stage further down.
  logic s1_en, s2_en, s3_en;

  always_comb begin
    s3_en = !s3_valid_q || bus.out_ready;
    s2_en = !s2_valid_q || s3_en;
    s1_en = !s1_valid_q || s2_en;
  end

  // Stage 1: sign and magnitude. INT_MIN negates to itself, which reads as 2^31 unsigned.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_abs_d   = s1_abs_q;
    s1_tag_d   = s1_tag_q;
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d = bus.in_data[31];
        s1_zero_d = (bus.in_data == 32'd0);
        s1_abs_d  = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;
        s1_tag_d  = bus.in_tag;
      end
    end
  end

  // Stage 2: locate the leading one and shift it to bit 31
  logic [4:0]  lead_pos;
  logic [31:0] norm;

  always_comb begin
    lead_pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_abs_q[i]) lead_pos = 5'(i);
    end
    norm = s1_abs_q << (5'd31 - lead_pos);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_pos_d   = s2_pos_q;
    s2_norm_d  = s2_norm_q;
    s2_tag_d   = s2_tag_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_zero_d = s1_zero_q;
        s2_pos_d  = lead_pos;
        s2_norm_d = norm;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  // Stage 3: round to nearest even and pack. A rounding carry out of the
  // fraction leaves it all zero and bumps the exponent. The largest exponent
  // is 158 (from 2^31), so it never overflows.
  logic [22:0] frac;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] frac_sum;
  logic [7:0]  biased_exp;
  logic [31:0] packed_res;

  always_comb begin
    frac       = s2_norm_q[30:8];
    guard_bit  = s2_norm_q[7];
    sticky_bit = |s2_norm_q[6:0];
    round_up   = guard_bit && (sticky_bit || frac[0]);
    frac_sum   = {1'b0, frac} + {23'd0, round_up};
    biased_exp = 8'd127 + {3'd0, s2_pos_q} + {7'd0, frac_sum[23]};
    packed_res = s2_zero_q ? 32'd0 : {s2_sign_q, biased_exp, frac_sum[22:0]};
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_tag_d   = s3_tag_q;
    if (s3_en) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_data_d = packed_res;
        s3_tag_d  = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_abs_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_pos_q   <= '0;
      s2_norm_q  <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_abs_q   <= s1_abs_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_pos_q   <= s2_pos_d;
      s2_norm_q  <= s2_norm_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  always_comb begin
    bus.in_ready  = s1_en;
    bus.out_valid = s3_valid_q;
    bus.out_data  = s3_data_q;
    bus.out_tag   = s3_tag_q;
  end

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed and random checks of itof_pipe against an arithmetic
// int-to-float reference with a FIFO scoreboard.
module tb_itof_pipe;
  localparam int unsigned TagW = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  itof_pipe_if #(.TAG_W(TagW)) bus ();

  itof_pipe #(.TAG_W(TagW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0]     exp_data_q[$];
  logic [TagW-1:0] exp_tag_q[$];
  int              exp_cyc_q[$];

  logic [31:0]     cur_exp;
  bit              check_lat = 1'b0;
  bit              last_in_fire = 1'b0;
  bit              prev_stall = 1'b0;
  logic [31:0]     prev_data;
  logic [TagW-1:0] prev_tag;

  // Reference: integer to single precision by exact integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] x);
    longint mag, q, r, half;
    int     p, sh;
    logic   s;
    if (x == 32'd0) return 32'd0;
    s   = x[31];
    mag = s ? (longint'(64'h1_0000_0000) - longint'({32'd0, x})) : longint'({32'd0, x});
    p   = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      r    = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = longint'(1) << 23;
        p = p + 1;
      end
    end
    return {s, 8'(p + 127), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic [31:0]     ed;
    logic [TagW-1:0] et;
    int              ec;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", bus.out_data, prev_data);
      check("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_tag   = bus.out_tag;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_data_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        ed = exp_data_q.pop_front();
        et = exp_tag_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("out_data", bus.out_data, ed);
        check("out_tag", 32'(bus.out_tag), 32'(et));
        if (check_lat) check("latency", 32'(cyc - ec), 32'd3);
      end
    end
    last_in_fire = bus.in_valid && bus.in_ready;
    if (last_in_fire) begin
      exp_data_q.push_back(cur_exp);
      exp_tag_q.push_back(bus.in_tag);
      exp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] d, input logic [TagW-1:0] t, input logic [31:0] e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_tag   = t;
    cur_exp      = e;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (last_in_fire) return;
    end
    check("send_timeout", 32'(last_in_fire), 32'd1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_data_q.size() == 0) break;
      cycle();
    end
    check("drain_left", 32'(exp_data_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_int();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom >> $urandom_range(0, 31);
      2:       v = -($urandom >> $urandom_range(0, 31));
      default: begin
        v = 32'h0100_0000 + 32'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    int          acc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, back-to-back at full rate
    check_lat = 1'b1;
    send(32'd0,          5'd1,  32'h0000_0000);
    send(32'd1,          5'd2,  32'h3F80_0000);
    send(32'hFFFF_FFFF,  5'd3,  32'hBF80_0000);
    send(32'd3,          5'd4,  32'h4040_0000);
    send(32'h7FFF_FFFF,  5'd5,  32'h4F00_0000);
    send(32'h8000_0000,  5'd6,  32'hCF00_0000);
    send(32'h00FF_FFFF,  5'd7,  32'h4B7F_FFFF);
    send(32'd16777217,   5'd8,  32'h4B80_0000);
    send(32'd16777219,   5'd9,  32'h4B80_0002);
    send(32'd16777221,   5'd10, 32'h4B80_0002);
    send(-32'd16777219,  5'd11, 32'hCB80_0002);
    drain();

    // Random values at full rate with latency checks
    for (int i = 0; i < 40; i++) begin
      d = rand_int();
      send(d, 5'($urandom_range(0, 31)), model(d));
    end
    drain();

    // Random values with random valid and ready gaps
    check_lat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        d            = rand_int();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_tag   = 5'($urandom_range(0, 31));
        cur_exp      = model(d);
      end else begin
        bus.in_valid = 1'b0;
      end
      cycle();
    end
    drain();

    // Backpressure: only three requests fit while the output is stalled
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      d            = -32'(acc + 1) * 32'd1234567;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_tag   = 5'(acc + 1);
      cur_exp      = model(d);
      cycle();
      if (last_in_fire) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    while (acc < 6) begin
      d = -32'(acc + 1) * 32'd1234567;
      send(d, 5'(acc + 1), model(d));
      acc++;
    end
    drain();

    // Bubble collapse: B and C enter while A waits at the output
    send(32'd1000, 5'd20, model(32'd1000));
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd2000;
    bus.in_tag    = 5'd21;
    cur_exp       = model(32'd2000);
    cycle();
    check("bubble_b_accept", 32'(last_in_fire), 32'd1);
    bus.in_data = 32'd3000;
    bus.in_tag  = 5'd22;
    cur_exp     = model(32'd3000);
    cycle();
    check("bubble_c_accept", 32'(last_in_fire), 32'd1);
    check("bubble_a_waiting", 32'(bus.out_tag), 32'd20);
    drain();

    // Asynchronous reset with requests in flight
    check_lat = 1'b1;
    send(32'd11, 5'd1, model(32'd11));
    send(32'd22, 5'd2, model(32'd22));
    send(32'd33, 5'd3, model(32'd33));
    bus.in_valid = 1'b0;
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_data", bus.out_data, 32'd0);
    check("async_rst_tag", 32'(bus.out_tag), 32'd0);
    exp_data_q.delete();
    exp_tag_q.delete();
    exp_cyc_q.delete();
    prev_stall = 1'b0;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end
    send(32'hFFFF_FF85, 5'd9, model(32'hFFFF_FF85));
    bus.in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
